invader_formation: RTL and testbench

//  Downstream consumer of the VGA timing generator (hpos/vpos/display_on/hsync/vsync).

---
 rtl/space_invaders_pkg.sv | 41 ++++
 rtl/invader_formation_if.sv | 42 ++++
 rtl/invader_sprite_rom.sv | 55 +++++
 rtl/invader_formation.sv | 212 +++++++++++++++++++++
 tb/tb_invader_formation.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/space_invaders_pkg.sv
// Shared constants and types for the invader formation slice: VGA display
// extents, formation geometry, sprite scaling and the march state encoding.
package space_invaders_pkg;

    localparam int H_DISPLAY = 640;
    localparam int V_DISPLAY = 480;

    localparam int COLS      = 8;
    localparam int ROWS      = 4;
    localparam int X_SPACING = 32;
    localparam int Y_SPACING = 32;

    localparam int COL_W   = $clog2(COLS);
    localparam int ROW_W   = $clog2(ROWS);
    localparam int IDX_W   = $clog2(COLS * ROWS);
    localparam int X_SHIFT = $clog2(X_SPACING);
    localparam int Y_SHIFT = $clog2(Y_SPACING);

    localparam int SPRITE_PIX   = 8;
    localparam int SPRITE_SCALE = 2;
    localparam int SPRITE_W     = SPRITE_PIX * SPRITE_SCALE;
    localparam int SCALE_SHIFT  = $clog2(SPRITE_SCALE);
    localparam int SPR_IDX_W    = $clog2(SPRITE_PIX);

    // Bounding box of the whole formation, used by the march limits.
    localparam int FORM_W = (COLS - 1) * X_SPACING + SPRITE_W;
    localparam int FORM_H = (ROWS - 1) * Y_SPACING + SPRITE_W;

    typedef enum logic [1:0] {
        MARCH_R = 2'd0,
        MARCH_L = 2'd1,
        DESCEND = 2'd2
    } march_state_t;

    // Linear invader index row*COLS+col; COLS is a power of two.
    function automatic logic [IDX_W-1:0] cell_index(input logic [ROW_W-1:0] row,
                                                    input logic [COL_W-1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/invader_formation_if.sv
// Bundle between the raster/bullet logic and the invader formation block:
// raster timing in, hit requests in, pixel/sync/status out.
interface invader_formation_if;
    import space_invaders_pkg::*;

    logic [9:0]           hpos;
    logic [9:0]           vpos;
    logic                 display_on;
    logic                 hsync_in;
    logic                 vsync_in;
    logic                 hit_valid;
    logic [COL_W-1:0]     hit_col;
    logic [ROW_W-1:0]     hit_row;
    logic                 restart;

    logic                 pix_on;
    logic                 hsync_o;
    logic                 vsync_o;
    logic                 frame_tick;
    logic [COLS*ROWS-1:0] alive_mask;
    logic                 all_dead;
    logic                 reached_bottom;
    // Formation position/state, exported for status displays and debug.
    logic [9:0]           form_x;
    logic [9:0]           form_y;
    march_state_t         march_state;

    modport master (
        output hpos, vpos, display_on, hsync_in, vsync_in,
               hit_valid, hit_col, hit_row, restart,
        input  pix_on, hsync_o, vsync_o, frame_tick, alive_mask,
               all_dead, reached_bottom, form_x, form_y, march_state
    );

    modport slave (
        input  hpos, vpos, display_on, hsync_in, vsync_in,
               hit_valid, hit_col, hit_row, restart,
        output pix_on, hsync_o, vsync_o, frame_tick, alive_mask,
               all_dead, reached_bottom, form_x, form_y, march_state
    );

endinterface

// File: rtl/invader_sprite_rom.sv
// Combinational 8x8 invader bitmap lookup. With INVADER_ANIM_EN defined a
// second bitmap is stored and frame_sel picks between them.
module invader_sprite_rom
    import space_invaders_pkg::*;
(
`ifdef INVADER_ANIM_EN
    input  logic                 frame_sel,
`endif
    input  logic [SPR_IDX_W-1:0] row,
    input  logic [SPR_IDX_W-1:0] col,
    output logic                 pix
);

    // MSB of each row word is the leftmost sprite pixel.
    function automatic logic [7:0] frame0_row(input logic [2:0] r);
        case (r)
            3'd0:    return 8'h18;
            3'd1:    return 8'h3C;
            3'd2:    return 8'h7E;
            3'd3:    return 8'hDB;
            3'd4:    return 8'hFF;
            3'd5:    return 8'h24;
            3'd6:    return 8'h5A;
            default: return 8'hA5;
        endcase
    endfunction

`ifdef INVADER_ANIM_EN
    function automatic logic [7:0] frame1_row(input logic [2:0] r);
        case (r)
            3'd0:    return 8'h18;
            3'd1:    return 8'h3C;
            3'd2:    return 8'h7E;
            3'd3:    return 8'hDB;
            3'd4:    return 8'hFF;
            3'd5:    return 8'h5A;
            3'd6:    return 8'h81;
            default: return 8'h42;
        endcase
    endfunction
`endif

    logic [7:0] row_bits;

    always_comb begin
        row_bits = frame0_row(row);
`ifdef INVADER_ANIM_EN
        if (frame_sel) begin
            row_bits = frame1_row(row);
        end
`endif
        pix = row_bits[~col];
    end

endmodule

// File: rtl/invader_formation.sv
// Invader formation: marches every MOVE_DIV frames, tracks kills and renders a
// 1-bit invader pixel two cycles after hpos/vpos. Optional macro: INVADER_ANIM_EN.
module invader_formation
    import space_invaders_pkg::*;
#(
    parameter int START_X  = 64,
    parameter int START_Y  = 48,
    parameter int X_MIN    = 16,
    parameter int X_MAX    = H_DISPLAY - 16,
    parameter int STEP_X   = 4,
    parameter int STEP_Y   = 8,
    parameter int MOVE_DIV = 4,
    parameter int Y_LIMIT  = 440
) (
    input logic               clk,
    input logic               rst_n,
    invader_formation_if.slave bus
);

    localparam int N_CELLS = COLS * ROWS;

    logic [9:0]         form_x_reg;
    logic [9:0]         form_y_reg;
    logic [N_CELLS-1:0] alive_reg;
    logic [3:0]         div_reg;
    march_state_t       state_reg;
    march_state_t       next_dir_reg;
    logic               reached_bottom_reg;
    logic               frame_tick_reg;
`ifdef INVADER_ANIM_EN
    logic               anim_frame_reg;
`endif

    logic [N_CELLS-1:0] hit_clear;
    logic               frame_evt;
    logic               div_last;
    logic               all_dead;
    logic               bottom_hit;
    logic               right_block;
    logic               left_block;
    logic               do_step;

    genvar gi;
    generate
        for (gi = 0; gi < N_CELLS; gi++) begin : g_hit
            assign hit_clear[gi] = bus.hit_valid &&
                                   (cell_index(bus.hit_row, bus.hit_col) == IDX_W'(gi));
        end
    endgenerate

    assign frame_evt   = (bus.hpos == 10'd0) && (bus.vpos == 10'(V_DISPLAY));
    assign div_last    = (div_reg == 4'(MOVE_DIV - 1));
    assign all_dead    = (alive_reg == '0);
    assign bottom_hit  = ({1'b0, form_y_reg} + 11'(FORM_H)) >= 11'(Y_LIMIT);
    assign right_block = ({1'b0, form_x_reg} + 11'(FORM_W + STEP_X)) > 11'(X_MAX);
    assign left_block  = form_x_reg < 10'(X_MIN + STEP_X);
    // bottom_hit also gates the step so the cycle before the sticky flag registers is covered.
    assign do_step     = frame_evt && div_last && !all_dead && !reached_bottom_reg && !bottom_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            form_x_reg         <= 10'(START_X);
            form_y_reg         <= 10'(START_Y);
            alive_reg          <= '1;
            div_reg            <= '0;
            state_reg          <= MARCH_R;
            next_dir_reg       <= MARCH_L;
            reached_bottom_reg <= 1'b0;
            frame_tick_reg     <= 1'b0;
`ifdef INVADER_ANIM_EN
            anim_frame_reg     <= 1'b0;
`endif
        end else if (bus.restart) begin
            form_x_reg         <= 10'(START_X);
            form_y_reg         <= 10'(START_Y);
            alive_reg          <= '1;
            div_reg            <= '0;
            state_reg          <= MARCH_R;
            next_dir_reg       <= MARCH_L;
            reached_bottom_reg <= 1'b0;
            frame_tick_reg     <= 1'b0;
`ifdef INVADER_ANIM_EN
            anim_frame_reg     <= 1'b0;
`endif
        end else begin
            frame_tick_reg <= frame_evt;
            alive_reg      <= alive_reg & ~hit_clear;
            if (frame_evt) begin
                div_reg <= div_last ? 4'd0 : div_reg + 4'd1;
            end
            if (bottom_hit) begin
                reached_bottom_reg <= 1'b1;
            end
            if (do_step) begin
`ifdef INVADER_ANIM_EN
                anim_frame_reg <= ~anim_frame_reg;
`endif
                case (state_reg)
                    MARCH_R: begin
                        if (right_block) begin
                            state_reg    <= DESCEND;
                            next_dir_reg <= MARCH_L;
                        end else begin
                            form_x_reg <= form_x_reg + 10'(STEP_X);
                        end
                    end
                    MARCH_L: begin
                        if (left_block) begin
                            state_reg    <= DESCEND;
                            next_dir_reg <= MARCH_R;
                        end else begin
                            form_x_reg <= form_x_reg - 10'(STEP_X);
                        end
                    end
                    DESCEND: begin
                        form_y_reg <= form_y_reg + 10'(STEP_Y);
                        state_reg  <= next_dir_reg;
                    end
                    default: state_reg <= MARCH_R;
                endcase
            end
        end
    end

    // Render stage 1: offset into the formation, cell and sub-cell coordinates.
    logic [10:0]          dx;
    logic [10:0]          dy;
    logic                 in_x;
    logic                 in_y;

    assign dx   = {1'b0, bus.hpos} - {1'b0, form_x_reg};
    assign dy   = {1'b0, bus.vpos} - {1'b0, form_y_reg};
    assign in_x = !dx[10] && (dx[9:0] < 10'(COLS * X_SPACING));
    assign in_y = !dy[10] && (dy[9:0] < 10'(ROWS * Y_SPACING));

    logic                 d1_display_reg;
    logic                 d1_inrange_reg;
    logic [COL_W-1:0]     d1_col_reg;
    logic [ROW_W-1:0]     d1_row_reg;
    logic [X_SHIFT-1:0]   d1_sub_x_reg;
    logic [Y_SHIFT-1:0]   d1_sub_y_reg;
    logic                 pix_on_reg;
    logic [1:0]           hsync_d_reg;
    logic [1:0]           vsync_d_reg;

    logic [SPR_IDX_W-1:0] sprite_row;
    logic [SPR_IDX_W-1:0] sprite_col;
    logic                 rom_pix;
    logic                 cell_lit;

    assign sprite_row = SPR_IDX_W'(d1_sub_y_reg >> SCALE_SHIFT);
    assign sprite_col = SPR_IDX_W'(d1_sub_x_reg >> SCALE_SHIFT);
    assign cell_lit   = d1_display_reg && d1_inrange_reg &&
                        (d1_sub_x_reg < X_SHIFT'(SPRITE_W)) &&
                        (d1_sub_y_reg < Y_SHIFT'(SPRITE_W)) &&
                        alive_reg[cell_index(d1_row_reg, d1_col_reg)] && rom_pix;

    invader_sprite_rom u_rom (
`ifdef INVADER_ANIM_EN
        .frame_sel (anim_frame_reg),
`endif
        .row       (sprite_row),
        .col       (sprite_col),
        .pix       (rom_pix)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1_display_reg <= 1'b0;
            d1_inrange_reg <= 1'b0;
            d1_col_reg     <= '0;
            d1_row_reg     <= '0;
            d1_sub_x_reg   <= '0;
            d1_sub_y_reg   <= '0;
            pix_on_reg     <= 1'b0;
            hsync_d_reg    <= 2'b11;
            vsync_d_reg    <= 2'b11;
        end else if (bus.restart) begin
            d1_display_reg <= 1'b0;
            d1_inrange_reg <= 1'b0;
            d1_col_reg     <= '0;
            d1_row_reg     <= '0;
            d1_sub_x_reg   <= '0;
            d1_sub_y_reg   <= '0;
            pix_on_reg     <= 1'b0;
            hsync_d_reg    <= 2'b11;
            vsync_d_reg    <= 2'b11;
        end else begin
            d1_display_reg <= bus.display_on;
            d1_inrange_reg <= in_x && in_y;
            d1_col_reg     <= dx[X_SHIFT +: COL_W];
            d1_row_reg     <= dy[Y_SHIFT +: ROW_W];
            d1_sub_x_reg   <= dx[X_SHIFT-1:0];
            d1_sub_y_reg   <= dy[Y_SHIFT-1:0];
            pix_on_reg     <= cell_lit;
            hsync_d_reg    <= {hsync_d_reg[0], bus.hsync_in};
            vsync_d_reg    <= {vsync_d_reg[0], bus.vsync_in};
        end
    end

    assign bus.pix_on         = pix_on_reg;
    assign bus.hsync_o        = hsync_d_reg[1];
    assign bus.vsync_o        = vsync_d_reg[1];
    assign bus.frame_tick     = frame_tick_reg;
    assign bus.alive_mask     = alive_reg;
    assign bus.all_dead       = all_dead;
    assign bus.reached_bottom = reached_bottom_reg;
    assign bus.form_x         = form_x_reg;
    assign bus.form_y         = form_y_reg;
    assign bus.march_state    = state_reg;

endmodule

// File: tb/tb_invader_formation.sv
// Directed bench for invader_formation: reset, sprite rendering table, march,
// hits, bottom limit/restart and sync/frame_tick timing.
module tb_invader_formation;
    import space_invaders_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #20 clk = ~clk;

    invader_formation_if bus();

    invader_formation dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [9:0] hpos;
        logic [9:0] vpos;
        logic       de;
        logic       exp;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [7:0] spr [8];
    vec_t       vecs[$];
    logic       hs_hist[$];
    logic       vs_hist[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.hpos = 10'd300;
        bus.vpos = 10'd200;
        bus.display_on = 1'b0;
        bus.hsync_in = 1'b1;
        bus.vsync_in = 1'b1;
        bus.hit_valid = 1'b0;
        bus.hit_col = '0;
        bus.hit_row = '0;
        bus.restart = 1'b0;
    endtask

    task automatic frames(input int n);
        bus.hpos = 10'd0;
        bus.vpos = 10'd480;
        repeat (n) tick();
        bus.hpos = 10'd300;
        bus.vpos = 10'd200;
    endtask

    task automatic hit(input int col, input int row);
        bus.hit_valid = 1'b1;
        bus.hit_col = 3'(col);
        bus.hit_row = 2'(row);
        tick();
        bus.hit_valid = 1'b0;
    endtask

    task automatic render_check(input string name, input int h, input int v, input logic exp);
        bus.hpos = 10'(h);
        bus.vpos = 10'(v);
        bus.display_on = 1'b1;
        tick();
        tick();
        check(name, 32'(bus.pix_on), 32'(exp));
        bus.display_on = 1'b0;
        bus.hpos = 10'd300;
        bus.vpos = 10'd200;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   n;
        bit   done;
        spr = '{8'h18, 8'h3C, 8'h7E, 8'hDB, 8'hFF, 8'h24, 8'h5A, 8'hA5};
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                v.hpos = 10'(64 + 2 * c);
                v.vpos = 10'(48 + 2 * r);
                v.de   = 1'b1;
                v.exp  = spr[r][7 - c];
                vecs.push_back(v);
            end
        end
        vecs.push_back('{10'd80,  10'd56,  1'b1, 1'b0});  // gap between columns
        vecs.push_back('{10'd70,  10'd56,  1'b0, 1'b0});  // lit pixel, blanking
        vecs.push_back('{10'd70,  10'd56,  1'b1, 1'b1});
        vecs.push_back('{10'd63,  10'd56,  1'b1, 1'b0});  // left of formation
        vecs.push_back('{10'd294, 10'd152, 1'b1, 1'b1});  // last cell (7,3)
        vecs.push_back('{10'd326, 10'd56,  1'b1, 1'b0});  // right of formation
        vecs.push_back('{10'd70,  10'd184, 1'b1, 1'b0});  // below formation
        vecs.push_back('{10'd134, 10'd80,  1'b1, 1'b1});  // cell (2,1) rom[0][3]

        // Reset and asynchronous reset in mid-line
        idle();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        frames(4);
        check("march_first_step_x", 32'(bus.form_x), 32'd68);
        bus.hsync_in = 1'b0;
        bus.vsync_in = 1'b0;
        bus.display_on = 1'b1;
        bus.hpos = 10'd74;
        bus.vpos = 10'd56;
        tick();
        tick();
        tick();
        check("pre_reset_pix", 32'(bus.pix_on), 32'd1);
        check("pre_reset_hsync", 32'(bus.hsync_o), 32'd0);
        bus.hpos = 10'd300;
        #5 rst_n = 1'b0;
        #1;
        check("rst_form_x", 32'(bus.form_x), 32'd64);
        check("rst_form_y", 32'(bus.form_y), 32'd48);
        check("rst_alive", bus.alive_mask, 32'hFFFF_FFFF);
        check("rst_hsync", 32'(bus.hsync_o), 32'd1);
        check("rst_vsync", 32'(bus.vsync_o), 32'd1);
        check("rst_pix", 32'(bus.pix_on), 32'd0);
        check("rst_state", 32'(bus.march_state), 32'(MARCH_R));
        check("rst_bottom", 32'(bus.reached_bottom), 32'd0);
        check("rst_all_dead", 32'(bus.all_dead), 32'd0);
        idle();
        #5 rst_n = 1'b1;
        tick();

        // Sprite rendering table, streamed one vector per cycle
        n = vecs.size();
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                bus.hpos = vecs[i].hpos;
                bus.vpos = vecs[i].vpos;
                bus.display_on = vecs[i].de;
            end else begin
                bus.display_on = 1'b0;
            end
            tick();
            if (i >= 1) check($sformatf("pix_vec%0d", i - 1), 32'(bus.pix_on), 32'(vecs[i - 1].exp));
        end
        idle();

        // March to the right limit, descend, turn left
        frames(4);
        check("march_x_68", 32'(bus.form_x), 32'd68);
        frames(316);
        check("march_x_384", 32'(bus.form_x), 32'd384);
        check("march_state_r", 32'(bus.march_state), 32'(MARCH_R));
        frames(4);
        check("edge_state_desc", 32'(bus.march_state), 32'(DESCEND));
        check("edge_x_hold", 32'(bus.form_x), 32'd384);
        frames(4);
        check("desc_y_56", 32'(bus.form_y), 32'd56);
        check("desc_x_384", 32'(bus.form_x), 32'd384);
        check("desc_state_l", 32'(bus.march_state), 32'(MARCH_L));
        frames(4);
        check("march_l_x_380", 32'(bus.form_x), 32'd380);

        // Hits
        bus.restart = 1'b1;
        tick();
        bus.restart = 1'b0;
        check("restart_x", 32'(bus.form_x), 32'd64);
        hit(3, 1);
        check("hit_3_1", bus.alive_mask, 32'hFFFF_F7FF);
        render_check("dead_cell_pix", 166, 88, 1'b0);
        render_check("live_cell_pix", 134, 88, 1'b1);
        hit(3, 1);
        check("hit_repeat", bus.alive_mask, 32'hFFFF_F7FF);
        frames(3);
        bus.hpos = 10'd0;
        bus.vpos = 10'd480;
        hit(0, 0);
        bus.hpos = 10'd300;
        bus.vpos = 10'd200;
        check("hit_step_x", 32'(bus.form_x), 32'd68);
        check("hit_step_mask", bus.alive_mask, 32'hFFFF_F7FE);
        for (int i = 0; i < 31; i++) hit(i % 8, i / 8);
        check("one_left_not_dead", 32'(bus.all_dead), 32'd0);
        hit(7, 3);
        check("all_dead", 32'(bus.all_dead), 32'd1);
        check("all_dead_mask", bus.alive_mask, 32'd0);
        frames(8);
        check("dead_x_frozen", 32'(bus.form_x), 32'd68);

        // March to the bottom limit
        bus.restart = 1'b1;
        tick();
        bus.restart = 1'b0;
        bus.hpos = 10'd0;
        bus.vpos = 10'd480;
        done = 1'b0;
        for (int i = 0; i < 20000 && !done; i++) begin
            tick();
            if (bus.reached_bottom) done = 1'b1;
        end
        check("bottom_reached", 32'(bus.reached_bottom), 32'd1);
        check("bottom_y", 32'(bus.form_y), 32'd328);
        check("bottom_x", 32'(bus.form_x), 32'd384);
        repeat (16) tick();
        check("bottom_sticky", 32'(bus.reached_bottom), 32'd1);
        check("bottom_y_frozen", 32'(bus.form_y), 32'd328);
        check("bottom_state", 32'(bus.march_state), 32'(MARCH_L));
        bus.restart = 1'b1;
        bus.hit_valid = 1'b1;
        bus.hit_col = 3'd2;
        bus.hit_row = 2'd2;
        tick();
        check("rs_alive", bus.alive_mask, 32'hFFFF_FFFF);
        check("rs_bottom", 32'(bus.reached_bottom), 32'd0);
        check("rs_x", 32'(bus.form_x), 32'd64);
        check("rs_y", 32'(bus.form_y), 32'd48);
        check("rs_state", 32'(bus.march_state), 32'(MARCH_R));
        check("rs_tick", 32'(bus.frame_tick), 32'd0);
        idle();

        // Sync re-timing and frame_tick
        for (int i = 0; i < 40; i++) begin
            bus.hsync_in = 1'($urandom);
            bus.vsync_in = 1'($urandom);
            hs_hist.push_back(bus.hsync_in);
            vs_hist.push_back(bus.vsync_in);
            tick();
            if (i >= 1) begin
                check($sformatf("hsync_%0d", i), 32'(bus.hsync_o), 32'(hs_hist[i - 1]));
                check($sformatf("vsync_%0d", i), 32'(bus.vsync_o), 32'(vs_hist[i - 1]));
            end
        end
        idle();
        bus.hpos = 10'd1;
        bus.vpos = 10'd480;
        tick();
        check("tick_h1", 32'(bus.frame_tick), 32'd0);
        bus.hpos = 10'd0;
        tick();
        check("tick_frame", 32'(bus.frame_tick), 32'd1);
        bus.vpos = 10'd481;
        tick();
        check("tick_v481", 32'(bus.frame_tick), 32'd0);
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
